// File: rtl/audio_loop_recorder.sv
// audio_loop_recorder
// Record/playback loop controller between the mic decimator and the DAC.
// While rec is held, decimated samples are captured into block RAM; while
// play is held, the captured clip is replayed in a continuous loop. All other
// times (and while recording) the live sample is passed straight through.
// Pass-through and playback both have a 2-clk sample_valid -> out_valid latency.
//
// Optional feature macro: REVERSE_PLAY_EN (adds rev_btn; reverse playback).
//
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   sample_valid/_in      one-cycle strobe + decimated mic sample
//   rec_btn, play_btn     async button levels (2-flop synchronized)
//   rev_btn               (REVERSE_PLAY_EN only) reverse direction request
//   audio_out, out_valid  sample to DAC + one-cycle update strobe
//   state                 debug view of FSM: 0 IDLE, 1 RECORD, 2 PLAY
//   clip_len              stored clip length in samples (0 = empty)
//   full                  last recording stopped on a full RAM
//
// Handshake: sample_valid is a one-cycle strobe with no backpressure; every
// accepted strobe yields exactly one out_valid strobe 2 clk later.
module audio_loop_recorder #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              rec_btn,
  input  logic              play_btn,
`ifdef REVERSE_PLAY_EN
  input  logic              rev_btn,
`endif
  output logic [DATA_W-1:0] audio_out,
  output logic              out_valid,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   clip_len,
  output logic              full
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] A_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0] rec_sync, play_sync;
  logic       rec_s, play_s, rec_eff;
  logic       rec_lock;  // blocks a still-held rec after a full-RAM stop

  logic [ADDR_W-1:0] wr_addr, rd_addr, last_addr;
  logic              wr_en, rd_en, rec_start, play_start, rec_end, hit_full;
  logic              rev_dir;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] pass_d1;
  logic              valid_d1, src_play_d1;

  // Button synchronizers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_sync  <= 2'b00;
      play_sync <= 2'b00;
    end else begin
      rec_sync  <= {rec_sync[0], rec_btn};
      play_sync <= {play_sync[0], play_btn};
    end
  end

  assign rec_s     = rec_sync[1];
  assign play_s    = play_sync[1];
  assign rec_eff   = rec_s & ~rec_lock;
  assign last_addr = clip_len[ADDR_W-1:0] - A_ONE;  // clip_len = DEPTH wraps to all ones

`ifdef REVERSE_PLAY_EN
  logic [1:0] rev_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rev_sync <= 2'b00;
      rev_dir  <= 1'b0;
    end else begin
      rev_sync <= {rev_sync[0], rev_btn};
      if (play_start) rev_dir <= rev_sync[1];  // direction fixed per session
    end
  end
`else
  assign rev_dir = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and control strobes
  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rec_start  = 1'b0;
    play_start = 1'b0;
    rec_end    = 1'b0;
    hit_full   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rec_eff) begin
          state_d   = S_RECORD;
          rec_start = 1'b1;
        end else if (play_s && (clip_len != '0)) begin
          state_d    = S_PLAY;
          play_start = 1'b1;
        end
      end
      S_RECORD: begin
        wr_en = sample_valid;
        // A full RAM takes precedence over a simultaneous rec drop.
        if (sample_valid && (wr_addr == MAX_ADDR)) begin
          hit_full = 1'b1;
          state_d  = S_IDLE;
        end else if (!rec_s) begin
          rec_end = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        rd_en = sample_valid;
        // rec during PLAY goes via IDLE, which then starts RECORD.
        if (rec_eff || !play_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address, length and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      clip_len <= '0;
      full     <= 1'b0;
      rec_lock <= 1'b0;
    end else begin
      if (rec_start) begin
        wr_addr <= '0;
        full    <= 1'b0;
      end else if (wr_en) begin
        wr_addr <= wr_addr + A_ONE;
      end

      if (hit_full) begin
        clip_len <= FULL_LEN;
        full     <= 1'b1;
      end else if (rec_end) begin
        // A strobe in the exit cycle is written and counted.
        clip_len <= {1'b0, wr_addr} + {{ADDR_W{1'b0}}, sample_valid};
      end

      if (hit_full)    rec_lock <= 1'b1;
      else if (!rec_s) rec_lock <= 1'b0;

      if (play_start) begin
        rd_addr <= rev_dir_next() ? last_addr : '0;
      end else if (rd_en) begin
        if (rev_dir) rd_addr <= (rd_addr == '0) ? last_addr : rd_addr - A_ONE;
        else         rd_addr <= (rd_addr == last_addr) ? '0 : rd_addr + A_ONE;
      end
    end
  end

  // Direction that the PLAY session about to start will use.
  function automatic logic rev_dir_next();
`ifdef REVERSE_PLAY_EN
    return rev_sync[1];
`else
    return 1'b0;
`endif
  endfunction

  // Sample RAM: simple dual port, 1-cycle read, no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= sample_in;
    if (rd_en) ram_q <= mem[rd_addr];
  end

  // Output pipeline: stage 1 matches the RAM read, stage 2 selects source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d1    <= 1'b0;
      pass_d1     <= '0;
      src_play_d1 <= 1'b0;
      out_valid   <= 1'b0;
      audio_out   <= '0;
    end else begin
      valid_d1    <= sample_valid;
      src_play_d1 <= (state_q == S_PLAY);
      if (sample_valid) pass_d1 <= sample_in;
      out_valid   <= valid_d1;
      if (valid_d1) audio_out <= src_play_d1 ? ram_q : pass_d1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_audio_loop_recorder.sv
module tb_audio_loop_recorder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_valid;
  logic [3:0]  sample_in;
  logic        rec_btn, play_btn;
`ifdef REVERSE_PLAY_EN
  logic        rev_btn;
`endif
  logic [3:0]  audio_out, audio_out_s;
  logic        out_valid, out_valid_s;
  logic [1:0]  state, state_s;
  logic [14:0] clip_len;
  logic [3:0]  clip_len_s;
  logic        full, full_s;

  int total = 0;
  int bad   = 0;

  // Reference model: stored clips as plain sample lists
  logic [3:0] exp_q[$];
  logic [3:0] clip_q[$];   // main instance (depth 16384)
  logic [3:0] clip_s[$];   // small instance (depth 8)

  // Clock/reset
  always #5 clk = ~clk;

  audio_loop_recorder dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_in(sample_in),
    .rec_btn(rec_btn), .play_btn(play_btn),
`ifdef REVERSE_PLAY_EN
    .rev_btn(rev_btn),
`endif
    .audio_out(audio_out), .out_valid(out_valid), .state(state),
    .clip_len(clip_len), .full(full)
  );

  audio_loop_recorder #(.DATA_W(4), .ADDR_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_in(sample_in),
    .rec_btn(rec_btn), .play_btn(play_btn),
`ifdef REVERSE_PLAY_EN
    .rev_btn(rev_btn),
`endif
    .audio_out(audio_out_s), .out_valid(out_valid_s), .state(state_s),
    .clip_len(clip_len_s), .full(full_s)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; sample_valid = 1'b0; sample_in = 4'h0;
    rec_btn = 1'b0; play_btn = 1'b0;
`ifdef REVERSE_PLAY_EN
    rev_btn = 1'b0;
`endif
    wait_clk(3);
    rst_n = 1'b1;
    clip_q.delete(); clip_s.delete(); exp_q.delete();
    wait_clk(1);
  endtask

  // One strobe; returns out_valid one clk after (must be 0) and the output 2 clk after.
  task automatic drive_strobe(input logic [3:0] d, output logic v_early, output logic v_on,
                              output logic [3:0] a, output logic v_on_s, output logic [3:0] a_s);
    @(posedge clk); #1;
    sample_valid = 1'b1; sample_in = d;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    v_early = out_valid;
    @(posedge clk); #1;
    v_on = out_valid; a = audio_out; v_on_s = out_valid_s; a_s = audio_out_s;
  endtask

  // Scenarios
  task automatic test_reset();
    apply_reset();
    total++; if (audio_out !== 4'h0) begin bad++; $display("FAIL reset_audio: got %0h want 0", audio_out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    total++; if (clip_len !== 15'd0) begin bad++; $display("FAIL reset_clip_len: got %0d want 0", clip_len); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
  endtask

  task automatic test_pass_through();
    logic ve, vo, vs; logic [3:0] a, as_, d, e;
    for (int i = 0; i < 6; i++) begin
      d = (i == 0) ? 4'h3 : (i == 1) ? 4'hA : 4'($urandom_range(0, 15));
      exp_q.push_back(d);
      drive_strobe(d, ve, vo, a, vs, as_);
      e = exp_q.pop_front();
      total++;
      if (ve !== 1'b0 || vo !== 1'b1 || a !== e)
        begin bad++; $display("FAIL pass[%0d]: out=%0h valid=%b early=%b want out=%0h valid=1 early=0", i, a, vo, ve, e); end
      wait_clk(5);
    end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL pass_state: got %0d want 0", state); end
  endtask

  task automatic test_record_play();
    logic ve, vo, vs; logic [3:0] a, as_, e;
    rec_btn = 1'b1;
    wait_clk(2);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rec_latency_early: got %0d want 0", state); end
    wait_clk(1);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL rec_latency: got %0d want 1", state); end
    clip_q.delete();
    for (int i = 1; i <= 5; i++) begin
      clip_q.push_back(4'(i));
      exp_q.push_back(4'(i));
      drive_strobe(4'(i), ve, vo, a, vs, as_);
      e = exp_q.pop_front();
      total++;
      if (ve !== 1'b0 || vo !== 1'b1 || a !== e)
        begin bad++; $display("FAIL rec_pass[%0d]: out=%0h valid=%b want %0h", i, a, vo, e); end
    end
    rec_btn = 1'b0;
    wait_clk(4);
    total++; if (clip_len !== 15'd5) begin bad++; $display("FAIL rec_clip_len: got %0d want 5", clip_len); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rec_full: got %b want 0", full); end
    play_btn = 1'b1;
    wait_clk(4);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL play_state: got %0d want 2", state); end
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(clip_q[i % clip_q.size()]);
      drive_strobe(4'($urandom_range(0, 15)), ve, vo, a, vs, as_);
      e = exp_q.pop_front();
      total++;
      if (ve !== 1'b0 || vo !== 1'b1 || a !== e)
        begin bad++; $display("FAIL play[%0d]: out=%0h valid=%b early=%b want out=%0h", i, a, vo, ve, e); end
    end
    play_btn = 1'b0;
    wait_clk(4);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL play_exit: got %0d want 0", state); end
  endtask

  task automatic test_priority();
    logic ve, vo, vs; logic [3:0] a, as_, d, e;
    rec_btn = 1'b1; play_btn = 1'b1;
    wait_clk(4);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL prio_state: got %0d want 1", state); end
    total++; if (clip_len !== 15'd5) begin bad++; $display("FAIL prio_len_hold: got %0d want 5", clip_len); end
    clip_q.delete();
    for (int i = 0; i < 3; i++) begin
      d = 4'($urandom_range(0, 15));
      clip_q.push_back(d);
      drive_strobe(d, ve, vo, a, vs, as_);
    end
    rec_btn = 1'b0; play_btn = 1'b0;
    wait_clk(4);
    total++; if (clip_len !== 15'd3) begin bad++; $display("FAIL prio_clip_len: got %0d want 3", clip_len); end
    play_btn = 1'b1;
    wait_clk(4);
    for (int i = 0; i < 5; i++) begin
      e = clip_q[i % clip_q.size()];
      drive_strobe(4'($urandom_range(0, 15)), ve, vo, a, vs, as_);
      total++;
      if (vo !== 1'b1 || a !== e) begin bad++; $display("FAIL prio_play[%0d]: out=%0h want %0h", i, a, e); end
    end
  endtask

  // Entered with play held.
  task automatic test_rec_during_play();
    logic ve, vo, vs; logic [3:0] a, as_, d;
    total++; if (state !== 2'd2) begin bad++; $display("FAIL rdp_pre: got %0d want 2", state); end
    rec_btn = 1'b1;
    wait_clk(3);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rdp_idle: got %0d want 0", state); end
    wait_clk(1);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL rdp_record: got %0d want 1", state); end
    clip_q.delete();
    for (int i = 0; i < 2; i++) begin
      d = 4'($urandom_range(0, 15));
      clip_q.push_back(d);
      drive_strobe(d, ve, vo, a, vs, as_);
    end
    rec_btn = 1'b0; play_btn = 1'b0;
    wait_clk(4);
    total++; if (clip_len !== 15'd2) begin bad++; $display("FAIL rdp_clip_len: got %0d want 2", clip_len); end
  endtask

  task automatic test_full();
    logic ve, vo, vs; logic [3:0] a, as_, d, e, es;
    rec_btn = 1'b1;
    wait_clk(4);
    clip_q.delete(); clip_s.delete();
    for (int i = 0; i < 10; i++) begin
      d = 4'($urandom_range(0, 15));
      clip_q.push_back(d);
      if (clip_s.size() < 8) clip_s.push_back(d);
      drive_strobe(d, ve, vo, a, vs, as_);
      total++;
      if (vs !== 1'b1 || as_ !== d) begin bad++; $display("FAIL full_pass[%0d]: out=%0h want %0h", i, as_, d); end
      if (i == 6) begin
        total++; if (state_s !== 2'd1) begin bad++; $display("FAIL full_before: got %0d want 1", state_s); end
      end
      if (i == 7) begin
        total++; if (state_s !== 2'd0) begin bad++; $display("FAIL full_after8: got %0d want 0", state_s); end
      end
    end
    wait_clk(4);
    total++; if (state_s !== 2'd0) begin bad++; $display("FAIL full_lock: got %0d want 0", state_s); end
    total++; if (clip_len_s !== 4'd8) begin bad++; $display("FAIL full_clip_len: got %0d want 8", clip_len_s); end
    total++; if (full_s !== 1'b1) begin bad++; $display("FAIL full_flag: got %b want 1", full_s); end
    rec_btn = 1'b0;
    wait_clk(4);
    total++; if (clip_len !== 15'd10) begin bad++; $display("FAIL full_main_len: got %0d want 10", clip_len); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL full_main_flag: got %b want 0", full); end
    play_btn = 1'b1;
    wait_clk(4);
    for (int i = 0; i < 12; i++) begin
      e  = clip_q[i % clip_q.size()];
      es = clip_s[i % clip_s.size()];
      drive_strobe(4'($urandom_range(0, 15)), ve, vo, a, vs, as_);
      total++;
      if (vo !== 1'b1 || a !== e || vs !== 1'b1 || as_ !== es)
        begin bad++; $display("FAIL full_play[%0d]: out=%0h small=%0h want %0h small=%0h", i, a, as_, e, es); end
    end
    play_btn = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_random();
    logic ve, vo, vs; logic [3:0] a, as_, d, e;
    int n, m;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 7);
      m = $urandom_range(3, 15);
      rec_btn = 1'b1;
      wait_clk(4);
      clip_q.delete();
      for (int i = 0; i < n; i++) begin
        d = 4'($urandom_range(0, 15));
        clip_q.push_back(d);
        drive_strobe(d, ve, vo, a, vs, as_);
      end
      rec_btn = 1'b0;
      wait_clk(4);
      total++; if (clip_len !== 15'(n)) begin bad++; $display("FAIL rnd_len[%0d]: got %0d want %0d", r, clip_len, n); end
      play_btn = 1'b1;
      wait_clk(4);
      for (int i = 0; i < m; i++) begin
        e = clip_q[i % n];
        drive_strobe(4'($urandom_range(0, 15)), ve, vo, a, vs, as_);
        total++;
        if (ve !== 1'b0 || vo !== 1'b1 || a !== e)
          begin bad++; $display("FAIL rnd_play[%0d.%0d]: out=%0h valid=%b want %0h", r, i, a, vo, e); end
      end
      play_btn = 1'b0;
      wait_clk(4);
    end
  endtask

`ifdef REVERSE_PLAY_EN
  task automatic test_reverse();
    logic ve, vo, vs; logic [3:0] a, as_, e;
    rec_btn = 1'b1;
    wait_clk(4);
    clip_q.delete();
    for (int i = 1; i <= 4; i++) begin
      clip_q.push_back(4'(i));
      drive_strobe(4'(i), ve, vo, a, vs, as_);
    end
    rec_btn = 1'b0;
    wait_clk(4);
    rev_btn = 1'b1; play_btn = 1'b1;
    wait_clk(4);
    for (int i = 0; i < 6; i++) begin
      e = clip_q[clip_q.size() - 1 - (i % clip_q.size())];
      drive_strobe(4'($urandom_range(0, 15)), ve, vo, a, vs, as_);
      total++;
      if (vo !== 1'b1 || a !== e) begin bad++; $display("FAIL rev_play[%0d]: out=%0h want %0h", i, a, e); end
    end
    rev_btn = 1'b0; play_btn = 1'b0;
    wait_clk(4);
  endtask
`endif

  task automatic test_empty_play();
    logic ve, vo, vs; logic [3:0] a, as_, d;
    apply_reset();
    play_btn = 1'b1;
    wait_clk(5);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL empty_state: got %0d want 0", state); end
    d = 4'($urandom_range(0, 15));
    drive_strobe(d, ve, vo, a, vs, as_);
    total++; if (vo !== 1'b1 || a !== d) begin bad++; $display("FAIL empty_pass: out=%0h want %0h", a, d); end
    play_btn = 1'b0;
    wait_clk(2);
  endtask

  task automatic test_reset_mid_record();
    logic ve, vo, vs; logic [3:0] a, as_;
    rec_btn = 1'b1;
    wait_clk(4);
    for (int i = 0; i < 3; i++) drive_strobe(4'($urandom_range(1, 15)), ve, vo, a, vs, as_);
    rst_n = 1'b0;
    #2;
    total++;
    if (audio_out !== 4'h0 || out_valid !== 1'b0 || state !== 2'd0 || clip_len !== 15'd0 || full !== 1'b0)
      begin bad++; $display("FAIL rst_mid_rec: out=%0h v=%b st=%0d len=%0d full=%b want all 0", audio_out, out_valid, state, clip_len, full); end
    rec_btn = 1'b0;
    clip_q.delete();
    wait_clk(1);
    rst_n = 1'b1;
    play_btn = 1'b1;
    wait_clk(5);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_mid_rec_play: got %0d want 0", state); end
    play_btn = 1'b0;
    wait_clk(2);
  endtask

  task automatic test_reset_mid_play();
    logic ve, vo, vs; logic [3:0] a, as_;
    rec_btn = 1'b1;
    wait_clk(4);
    for (int i = 0; i < 3; i++) drive_strobe(4'($urandom_range(0, 15)), ve, vo, a, vs, as_);
    rec_btn = 1'b0;
    wait_clk(4);
    play_btn = 1'b1;
    wait_clk(4);
    @(posedge clk); #1;
    sample_valid = 1'b1; sample_in = 4'h0;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_play_now: got %b want 0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || state !== 2'd0) begin bad++; $display("FAIL rst_mid_play_next: v=%b st=%0d want 0 0", out_valid, state); end
    play_btn = 1'b0;
    rst_n = 1'b1;
    wait_clk(2);
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_record_play();
    test_priority();
    test_rec_during_play();
    test_full();
    test_random();
`ifdef REVERSE_PLAY_EN
    test_reverse();
`endif
    test_empty_play();
    test_reset_mid_record();
    test_reset_mid_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
